// File: rtl/v_alu_seq.sv
// v_alu_seq: sequential element-wise vector ALU.
// A request is latched in IDLE, then LANES elements are produced per cycle in
// BUSY until all VLMAX elements are in the result register, then the result is
// offered in DONE until the consumer takes it.
// VLMAX must be a multiple of LANES.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid        request valid
//   in_ready        unit idle and able to accept a request
//   alu_opcode_i    NOP(0) / ADD(1) / SUB(2) / MUL(3) / MACC(4); others act as NOP
//   vl_i            active element count (values above VLMAX clamp to VLMAX)
//   operand_vs1_i   source 1 vector
//   operand_vs2_i   source 2 vector
//   operand_vd_i    old destination: MACC addend and tail source
//   out_valid       result valid
//   out_ready       consumer accepts result
//   vexe_result_o   result vector (element e at bits [e*ELEN +: ELEN])
module v_alu_seq #(
    parameter int unsigned ELEN  = 32,
    parameter int unsigned VLMAX = 8,
    parameter int unsigned LANES = 2,
    parameter int unsigned OPW   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OPW-1:0]            alu_opcode_i,
    input  logic [$clog2(VLMAX):0]    vl_i,
    input  logic [VLMAX*ELEN-1:0]     operand_vs1_i,
    input  logic [VLMAX*ELEN-1:0]     operand_vs2_i,
    input  logic [VLMAX*ELEN-1:0]     operand_vd_i,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [VLMAX*ELEN-1:0]     vexe_result_o
);

    localparam int unsigned VW      = VLMAX * ELEN;
    localparam int unsigned CHUNK_W = LANES * ELEN;
    localparam int unsigned NCHUNK  = VLMAX / LANES;
    localparam int unsigned CNT_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned VL_W    = $clog2(VLMAX) + 1;

    localparam logic [OPW-1:0] VALU_OP_NOP  = OPW'(0);
    localparam logic [OPW-1:0] VALU_OP_ADD  = OPW'(1);
    localparam logic [OPW-1:0] VALU_OP_SUB  = OPW'(2);
    localparam logic [OPW-1:0] VALU_OP_MUL  = OPW'(3);
    localparam logic [OPW-1:0] VALU_OP_MACC = OPW'(4);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [OPW-1:0]     op_q;
    logic [VL_W-1:0]    vl_q;
    logic [VW-1:0]      vs1_q;
    logic [VW-1:0]      vs2_q;
    logic [VW-1:0]      vd_q;
    logic [VW-1:0]      result_q;
    logic [CHUNK_W-1:0] chunk_c;
    logic               last_chunk_c;

    assign last_chunk_c  = (cnt == CNT_W'(NCHUNK - 1));
    assign vexe_result_o = result_q;

    // Results for the LANES elements of the current chunk, from latched operands.
    always_comb begin
        chunk_c = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            int unsigned     e;
            logic [ELEN-1:0] a;
            logic [ELEN-1:0] b;
            logic [ELEN-1:0] d;
            logic [ELEN-1:0] r;
            logic            active;
            e      = 32'(cnt) * LANES + l;
            a      = vs1_q[e*ELEN +: ELEN];
            b      = vs2_q[e*ELEN +: ELEN];
            d      = vd_q[e*ELEN +: ELEN];
            active = (e < 32'(vl_q));
            case (op_q)
                VALU_OP_ADD:  r = active ? (a + b)     : d;
                VALU_OP_SUB:  r = active ? (b - a)     : d;
                VALU_OP_MUL:  r = active ? (a * b)     : d;
                VALU_OP_MACC: r = active ? (d + a * b) : d;
                VALU_OP_NOP:  r = '0;
                default:      r = '0;
            endcase
            chunk_c[l*ELEN +: ELEN] = r;
        end
    end

    // Control FSM, operand latches and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            cnt       <= '0;
            op_q      <= '0;
            vl_q      <= '0;
            vs1_q     <= '0;
            vs2_q     <= '0;
            vd_q      <= '0;
            result_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        op_q     <= alu_opcode_i;
                        vl_q     <= (vl_i > VL_W'(VLMAX)) ? VL_W'(VLMAX) : vl_i;
                        vs1_q    <= operand_vs1_i;
                        vs2_q    <= operand_vs2_i;
                        vd_q     <= operand_vd_i;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    result_q[32'(cnt)*CHUNK_W +: CHUNK_W] <= chunk_c;
                    if (last_chunk_c) begin
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    // in_ready stays low here; a new request is taken only from IDLE.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_v_alu_seq.sv
// Self-checking bench for v_alu_seq: directed steps, expected vectors queued
// at accept and compared when the result is offered.
module tb_v_alu_seq;

    localparam int ELEN  = 32;
    localparam int VLMAX = 8;
    localparam int LANES = 2;
    localparam int OPW   = 8;
    localparam int VW    = VLMAX * ELEN;
    localparam int NCH   = VLMAX / LANES;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [OPW-1:0]  alu_opcode_i;
    logic [3:0]      vl_i;
    logic [VW-1:0]   operand_vs1_i;
    logic [VW-1:0]   operand_vs2_i;
    logic [VW-1:0]   operand_vd_i;
    logic            out_valid;
    logic            out_ready;
    logic [VW-1:0]   vexe_result_o;

    v_alu_seq #(.ELEN(ELEN), .VLMAX(VLMAX), .LANES(LANES), .OPW(OPW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_opcode_i  (alu_opcode_i),
        .vl_i          (vl_i),
        .operand_vs1_i (operand_vs1_i),
        .operand_vs2_i (operand_vs2_i),
        .operand_vd_i  (operand_vd_i),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .vexe_result_o (vexe_result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [VW-1:0] sb[$];
    int tests = 0;
    int fails = 0;
    int acc_cyc = 0;

    function automatic logic [VW-1:0] model(input logic [OPW-1:0] op, input int vl,
                                            input logic [VW-1:0] a, input logic [VW-1:0] b,
                                            input logic [VW-1:0] d);
        logic [VW-1:0] r;
        int vle;
        r   = '0;
        vle = (vl > VLMAX) ? VLMAX : vl;
        for (int e = 0; e < VLMAX; e++) begin
            logic [ELEN-1:0] x, y, z, o;
            x = a[e*ELEN +: ELEN];
            y = b[e*ELEN +: ELEN];
            z = d[e*ELEN +: ELEN];
            if (!(op inside {8'd1, 8'd2, 8'd3, 8'd4})) o = '0;
            else if (e >= vle) o = z;
            else if (op == 8'd1) o = x + y;
            else if (op == 8'd2) o = y - x;
            else if (op == 8'd3) o = x * y;
            else o = z + x * y;
            r[e*ELEN +: ELEN] = o;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", name, got, exp);
        end
    endtask

    // Caller is at a negedge; request is presented immediately.
    task automatic send(input logic [OPW-1:0] op, input int vl, input logic [VW-1:0] a,
                        input logic [VW-1:0] b, input logic [VW-1:0] d, input bit push);
        int k;
        alu_opcode_i  = op;
        vl_i          = 4'(vl);
        operand_vs1_i = a;
        operand_vs2_i = b;
        operand_vd_i  = d;
        in_valid      = 1'b1;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("send_ready", VW'(in_ready), VW'(1));
        @(posedge clk);
        acc_cyc = cyc;
        if (push) sb.push_back(model(op, vl, a, b, d));
        @(negedge clk);
        in_valid      = 1'b0;
        alu_opcode_i  = 8'(($urandom() % 4) + 1);
        vl_i          = 4'($urandom());
        operand_vs1_i = {8{$urandom()}};
        operand_vs2_i = {8{$urandom()}};
        operand_vd_i  = {8{$urandom()}};
    endtask

    // Wait for out_valid (bounded), check latency and popped expectation.
    task automatic wait_out(input string name, output logic [VW-1:0] exp);
        int k;
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({name, "_latency"}, VW'(k), VW'(NCH));
        check({name, "_sb_nonempty"}, VW'(sb.size() > 0), VW'(1));
        exp = (sb.size() > 0) ? sb.pop_front() : '0;
        check(name, vexe_result_o, exp);
    endtask

    // Receive with out_ready already high: out_valid must be high for one cycle.
    task automatic recv(input string name);
        logic [VW-1:0] exp;
        wait_out(name, exp);
        @(negedge clk);
        check({name, "_ov_drop"}, VW'(out_valid), VW'(0));
        check({name, "_in_ready"}, VW'(in_ready), VW'(1));
    endtask

    logic [VW-1:0] va, vb, vd, held, expv;
    int a1;
    bit seen;

    initial begin
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        out_ready     = 1'b1;
        alu_opcode_i  = '0;
        vl_i          = '0;
        operand_vs1_i = '0;
        operand_vs2_i = '0;
        operand_vd_i  = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", VW'(in_ready), VW'(1));
        check("rst_out_valid", VW'(out_valid), VW'(0));
        check("rst_result", vexe_result_o, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD full length, then back-to-back SUB for throughput
        for (int e = 0; e < VLMAX; e++) begin
            va[e*ELEN +: ELEN] = 32'(e);
            vb[e*ELEN +: ELEN] = 32'(10 * e);
            vd[e*ELEN +: ELEN] = 32'hDEAD0000 + 32'(e);
        end
        send(8'd1, 8, va, vb, vd, 1'b1);
        a1 = acc_cyc;
        recv("add_vl8");
        check("add_elem7", VW'(vexe_result_o[7*ELEN +: ELEN]), VW'(77));

        send(8'd2, 8, {8{32'd1}}, {8{32'd0}}, vd, 1'b1);
        check("throughput", VW'(acc_cyc - a1), VW'(NCH + 2));
        recv("sub_wrap");
        check("sub_elem0", VW'(vexe_result_o[ELEN-1:0]), VW'(32'hFFFFFFFF));

        send(8'd3, 8, {8{32'h10000}}, {8{32'h10000}}, vd, 1'b1);
        recv("mul_trunc");
        send(8'd4, 8, {8{32'd3}}, {8{32'd4}}, {8{32'd5}}, 1'b1);
        recv("macc");
        check("macc_elem5", VW'(vexe_result_o[5*ELEN +: ELEN]), VW'(17));

        // Tail-undisturbed and vl clamping
        for (int e = 0; e < VLMAX; e++) vd[e*ELEN +: ELEN] = 32'hAAAA0000 + 32'(e);
        send(8'd1, 3, {8{32'd1}}, {8{32'd1}}, vd, 1'b1);
        recv("add_vl3");
        check("add_vl3_e2", VW'(vexe_result_o[2*ELEN +: ELEN]), VW'(2));
        check("add_vl3_e3", VW'(vexe_result_o[3*ELEN +: ELEN]), VW'(32'hAAAA0003));
        send(8'd1, 12, {8{32'd1}}, {8{32'd1}}, vd, 1'b1);
        recv("add_vl12");
        send(8'd4, 0, {8{32'd7}}, {8{32'd9}}, vd, 1'b1);
        recv("macc_vl0");
        send(8'd0, 3, {8{32'd7}}, {8{32'd9}}, vd, 1'b1);
        recv("nop_zero");

        // Back-pressure: hold out_ready low in DONE, extra request ignored
        out_ready = 1'b0;
        send(8'd1, 8, va, vd, vb, 1'b1);
        wait_out("hold", held);
        in_valid      = 1'b1;
        alu_opcode_i  = 8'd2;
        vl_i          = 4'd8;
        operand_vs1_i = {8{32'h5}};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_out_valid", VW'(out_valid), VW'(1));
            check("hold_in_ready", VW'(in_ready), VW'(0));
            check("hold_result", vexe_result_o, held);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("release_ov", VW'(out_valid), VW'(0));
        check("release_ir", VW'(in_ready), VW'(1));
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid || !in_ready) seen = 1'b1;
        end
        check("extra_req_ignored", VW'(seen), VW'(0));
        check("result_held_idle", vexe_result_o, held);

        // Asynchronous reset during chunk 2
        for (int e = 0; e < VLMAX; e++) vb[e*ELEN +: ELEN] = 32'(100 + e);
        expv = model(8'd4, 8, va, vb, vd);
        send(8'd4, 8, va, vb, vd, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("partial_chunks01", VW'(vexe_result_o[4*ELEN-1:0]), VW'(expv[4*ELEN-1:0]));
        check("partial_ov", VW'(out_valid), VW'(0));
        #1 rst_n = 1'b0;
        #1;
        check("arst_ov", VW'(out_valid), VW'(0));
        check("arst_ir", VW'(in_ready), VW'(1));
        check("arst_result", vexe_result_o, '0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("no_spurious_out", VW'(seen), VW'(0));

        // Undefined opcode
        send(8'hFF, 8, va, vb, vd, 1'b1);
        recv("op_ff_zero");

        check("sb_empty", VW'(sb.size()), VW'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
